// File: rtl/vme_master_pkg.sv
// Shared types and constants for the VME master engine.
//   state_e   : bus-cycle FSM states
//   AM_A24_ND : address modifier driven on every cycle (A24 non-privileged data)
//   ERR_*     : completion status codes reported on vme_err
package vme_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWaitAck,
    StRelease,
    StDone
  } state_e;

  localparam logic [5:0] AM_A24_ND = 6'h39;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_BERR = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

endpackage

// File: rtl/vme_master_engine_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit bus response.
//   clk_i   : destination clock
//   rst_i   : synchronous active-high reset, loads ResetVal into both flops
//   d_i     : asynchronous input
//   q_o     : synchronized output
module vme_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vme_master_engine.sv
// VME A24/D16 bus master: runs one bus cycle per command pulse.
//   clk, rst               : clock, synchronous active-high reset
//   vme_cmd/addr/wr/rd/... : command port (sampled only while idle)
//   vme_cmd_rd             : one-cycle completion pulse
//   vme_rd_data, vme_err   : read data and completion status
//   busy                   : engine not idle
//   as_n, ds0_n, ds1_n,
//   write_n, am, a, d_out,
//   d_oe                   : VME bus drive
//   d_in, dtack_n, berr_n  : VME bus responses (dtack_n/berr_n asynchronous)
module vme_master_engine
  import vme_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vme_cmd,
  input  logic [23:1] vme_addr,
  input  logic        vme_wr,
  input  logic        vme_rd,
  input  logic [15:0] vme_wr_data,
  output logic        vme_cmd_rd,
  output logic [15:0] vme_rd_data,
  output logic [1:0]  vme_err,
  output logic        busy,
  output logic        as_n,
  output logic        ds0_n,
  output logic        ds1_n,
  output logic        write_n,
  output logic [5:0]  am,
  output logic [23:1] a,
  output logic [15:0] d_out,
  output logic        d_oe,
  input  logic [15:0] d_in,
  input  logic        dtack_n,
  input  logic        berr_n
);

  // Counter compares against "last" values so residency equals the parameter exactly.
  localparam logic [7:0] SetupLast = 8'(SETUP_CYC - 1);
  localparam logic [7:0] TmoLast   = 8'(TIMEOUT_CYC - 1);

  logic dtack_s;
  logic berr_s;

  vme_sync2 #(.ResetVal(1'b1)) u_sync_dtack (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (dtack_n),
    .q_o   (dtack_s)
  );

  vme_sync2 #(.ResetVal(1'b1)) u_sync_berr (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (berr_n),
    .q_o   (berr_s)
  );

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [23:1] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [1:0]  err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (vme_cmd) begin
          cnt_d = '0;
          if (vme_wr ^ vme_rd) begin
            addr_d  = vme_addr;
            wr_d    = vme_wr;
            wdata_d = vme_wr_data;
            err_d   = ERR_OK;
            state_d = StSetup;
          end else begin
            err_d   = ERR_ILL;
            state_d = StDone;
          end
        end
      end

      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StStrobe: begin
        cnt_d   = '0;
        state_d = StWaitAck;
      end

      StWaitAck: begin
        // BERR is checked first so it wins over a simultaneous DTACK.
        if (!berr_s) begin
          err_d   = ERR_BERR;
          cnt_d   = '0;
          state_d = StRelease;
          if (!wr_q) rd_data_d = 16'hFFFF;
        end else if (!dtack_s) begin
          cnt_d   = '0;
          state_d = StRelease;
          if (!wr_q) rd_data_d = d_in;
        end else if (cnt_q == TmoLast) begin
          err_d   = ERR_TMO;
          cnt_d   = '0;
          state_d = StRelease;
          if (!wr_q) rd_data_d = 16'hFFFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StRelease: begin
        if (dtack_s && berr_s) begin
          state_d = StDone;
        end else if (cnt_q == TmoLast) begin
          // Slave never released: report timeout even if an ack/BERR was seen.
          err_d   = ERR_TMO;
          state_d = StDone;
          if (!wr_q) rd_data_d = 16'hFFFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  logic strobe_on;
  logic bus_owned;

  assign strobe_on = (state_q == StStrobe) || (state_q == StWaitAck);
  assign bus_owned = (state_q == StSetup) || strobe_on || (state_q == StRelease);

  assign as_n        = ~strobe_on;
  assign ds0_n       = ~strobe_on;
  assign ds1_n       = ~strobe_on;
  assign write_n     = ~(wr_q && bus_owned);
  assign d_oe        = wr_q && (bus_owned && (state_q != StRelease));
  assign am          = AM_A24_ND;
  assign a           = addr_q;
  assign d_out       = wdata_q;
  assign busy        = (state_q != StIdle);
  assign vme_cmd_rd  = (state_q == StDone);
  assign vme_rd_data = rd_data_q;
  assign vme_err     = err_q;

endmodule

// File: tb/tb_vme_master_engine.sv
module tb_vme_master_engine;

  localparam int unsigned SetupCyc   = 2;
  localparam int unsigned TimeoutCyc = 16;

  localparam int RespDtack = 0;
  localparam int RespBerr  = 1;
  localparam int RespBoth  = 2;
  localparam int RespNone  = 3;
  localparam int RespStuck = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vme_cmd;
  logic [23:1] vme_addr;
  logic        vme_wr;
  logic        vme_rd;
  logic [15:0] vme_wr_data;
  logic        vme_cmd_rd;
  logic [15:0] vme_rd_data;
  logic [1:0]  vme_err;
  logic        busy;
  logic        as_n, ds0_n, ds1_n, write_n;
  logic [5:0]  am;
  logic [23:1] a;
  logic [15:0] d_out;
  logic        d_oe;
  logic [15:0] d_in;
  logic        dtack_n;
  logic        berr_n;

  int n_pass  = 0;
  int n_total = 0;

  // Responder and monitors
  int          resp_mode   = RespDtack;
  logic        ds_prev     = 1'b1;
  int          done_pulses = 0;
  int          doe_cycles  = 0;
  int          as_low_cyc  = 0;
  logic [15:0] model_rd    = 16'h0000;

  vme_master_engine #(
    .SETUP_CYC   (SetupCyc),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vme_cmd     (vme_cmd),
    .vme_addr    (vme_addr),
    .vme_wr      (vme_wr),
    .vme_rd      (vme_rd),
    .vme_wr_data (vme_wr_data),
    .vme_cmd_rd  (vme_cmd_rd),
    .vme_rd_data (vme_rd_data),
    .vme_err     (vme_err),
    .busy        (busy),
    .as_n        (as_n),
    .ds0_n       (ds0_n),
    .ds1_n       (ds1_n),
    .write_n     (write_n),
    .am          (am),
    .a           (a),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .d_in        (d_in),
    .dtack_n     (dtack_n),
    .berr_n      (berr_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ds_prev = ds0_n;
    if (vme_cmd_rd === 1'b1) done_pulses++;
    if (d_oe === 1'b1) doe_cycles++;
    if (as_n === 1'b0) as_low_cyc++;
  end

  // Slave responds one cycle after it sees DS change.
  always @(posedge clk) begin
    #2;
    case (resp_mode)
      RespDtack: begin dtack_n = ds_prev; berr_n = 1'b1;    end
      RespBerr:  begin dtack_n = 1'b1;    berr_n = ds_prev; end
      RespBoth:  begin dtack_n = ds_prev; berr_n = ds_prev; end
      RespStuck: begin dtack_n = 1'b0;    berr_n = 1'b1;    end
      default:   begin dtack_n = 1'b1;    berr_n = 1'b1;    end
    endcase
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete command with all per-transaction checks.
  task automatic run_txn(input logic wr, input logic rd, input logic [23:1] addr,
                         input logic [15:0] wdata, input int mode, input logic [15:0] rdata,
                         input logic poke, input string tag);
    logic        legal;
    logic [1:0]  exp_err;
    logic [15:0] exp_rd;
    int          exp_done;
    int          cyc;
    int          done_cyc;
    int          p0, doe0, as0;

    legal    = wr ^ rd;
    exp_done = -1;
    if (!legal) begin
      exp_err  = 2'b11;
      exp_done = 1;
    end else if (mode == RespDtack) begin
      exp_err = 2'b00;
    end else if (mode == RespBerr || mode == RespBoth) begin
      exp_err = 2'b01;
    end else begin
      exp_err  = 2'b10;
      exp_done = int'(SetupCyc + TimeoutCyc + 3);
    end
    exp_rd = model_rd;
    if (legal && rd) exp_rd = (exp_err == 2'b00) ? rdata : 16'hFFFF;

    resp_mode = mode;
    d_in      = rdata;
    p0        = done_pulses;
    doe0      = doe_cycles;
    as0       = as_low_cyc;

    vme_cmd     = 1'b1;
    vme_wr      = wr;
    vme_rd      = rd;
    vme_addr    = addr;
    vme_wr_data = wdata;
    @(posedge clk);
    #1;
    vme_cmd     = 1'b0;
    vme_addr    = 23'($urandom);
    vme_wr_data = 16'($urandom);
    cyc         = 1;
    done_cyc    = -1;

    while (cyc < 400 && done_cyc < 0) begin
      if (vme_cmd_rd === 1'b1) done_cyc = cyc;
      if (legal && cyc == 1) begin
        n_total++;
        if (a !== addr || write_n !== ~wr || d_oe !== wr || as_n !== 1'b1)
          $display("FAIL %s setup: a=%h write_n=%b d_oe=%b as_n=%b, want a=%h write_n=%b d_oe=%b as_n=1",
                   tag, a, write_n, d_oe, as_n, addr, ~wr, wr);
        else n_pass++;
        if (wr) begin
          n_total++;
          if (d_out !== wdata) $display("FAIL %s d_out: got %h want %h", tag, d_out, wdata);
          else n_pass++;
        end
      end
      if (legal && cyc == int'(SetupCyc)) begin
        n_total++;
        if (as_n !== 1'b1) $display("FAIL %s as_n late setup: got %b want 1", tag, as_n);
        else n_pass++;
      end
      if (legal && cyc == int'(SetupCyc) + 1) begin
        n_total++;
        if (as_n !== 1'b0 || ds0_n !== 1'b0 || ds1_n !== 1'b0 || a !== addr)
          $display("FAIL %s strobe: as_n=%b ds0_n=%b ds1_n=%b a=%h want 0 0 0 %h",
                   tag, as_n, ds0_n, ds1_n, a, addr);
        else n_pass++;
      end
      if (done_cyc < 0) begin
        vme_cmd = (poke && cyc == int'(SetupCyc) + 3);
        vme_wr  = 1'b1;
        vme_rd  = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    vme_cmd = 1'b0;

    n_total++;
    if (done_cyc < 0) begin
      $display("FAIL %s completion: none within 400 cycles", tag);
    end else begin
      n_pass++;
      n_total++;
      if (vme_err !== exp_err || vme_rd_data !== exp_rd)
        $display("FAIL %s result: err=%b rd_data=%h want err=%b rd_data=%h",
                 tag, vme_err, vme_rd_data, exp_err, exp_rd);
      else n_pass++;
      if (exp_done >= 0) begin
        n_total++;
        if (done_cyc != exp_done)
          $display("FAIL %s done cycle: got %0d want %0d", tag, done_cyc, exp_done);
        else n_pass++;
      end
      @(posedge clk);
      #1;
      n_total++;
      if (busy !== 1'b0 || vme_cmd_rd !== 1'b0 || as_n !== 1'b1 || done_pulses - p0 != 1)
        $display("FAIL %s after done: busy=%b cmd_rd=%b as_n=%b pulses=%0d want 0 0 1 1",
                 tag, busy, vme_cmd_rd, as_n, done_pulses - p0);
      else n_pass++;
    end

    if (rd || !legal) begin
      n_total++;
      if (doe_cycles != doe0) $display("FAIL %s d_oe: got %0d cycles want 0", tag, doe_cycles - doe0);
      else n_pass++;
    end
    if (!legal) begin
      n_total++;
      if (as_low_cyc != as0) $display("FAIL %s as_n: low %0d cycles want 0", tag, as_low_cyc - as0);
      else n_pass++;
    end

    model_rd  = exp_rd;
    resp_mode = RespDtack;
    idle_cycles(6);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    n_total++;
    if (as_n !== 1'b1 || ds0_n !== 1'b1 || ds1_n !== 1'b1 || write_n !== 1'b1 || d_oe !== 1'b0 ||
        a !== '0 || d_out !== '0 || am !== 6'h39 || vme_cmd_rd !== 1'b0 ||
        vme_rd_data !== '0 || vme_err !== 2'b00 || busy !== 1'b0)
      $display("FAIL reset: as_n=%b ds=%b%b write_n=%b d_oe=%b a=%h d_out=%h am=%h cmd_rd=%b rd=%h err=%b busy=%b",
               as_n, ds0_n, ds1_n, write_n, d_oe, a, d_out, am, vme_cmd_rd, vme_rd_data, vme_err, busy);
    else n_pass++;
    rst = 1'b0;
    model_rd = 16'h0000;
    idle_cycles(3);
  endtask

  task automatic test_write();
    run_txn(1'b1, 1'b0, 23'h0A0000, 16'h1234, RespDtack, 16'($urandom), 1'b0, "write");
  endtask

  task automatic test_read();
    run_txn(1'b0, 1'b1, 23'($urandom), 16'($urandom), RespDtack, 16'hBEEF, 1'b0, "read");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 23'($urandom), 16'($urandom), RespNone, 16'($urandom), 1'b0, "timeout");
  endtask

  task automatic test_berr();
    run_txn(1'b0, 1'b1, 23'($urandom), 16'($urandom), RespBoth, 16'($urandom), 1'b0, "berr_both");
    run_txn(1'b1, 1'b0, 23'($urandom), 16'($urandom), RespBerr, 16'($urandom), 1'b0, "berr_wr");
  endtask

  task automatic test_illegal();
    run_txn(1'b1, 1'b1, 23'($urandom), 16'($urandom), RespDtack, 16'($urandom), 1'b0, "ill_both");
    run_txn(1'b0, 1'b0, 23'($urandom), 16'($urandom), RespDtack, 16'($urandom), 1'b0, "ill_none");
  endtask

  task automatic test_cmd_while_busy();
    run_txn(1'b0, 1'b1, 23'($urandom), 16'($urandom), RespNone, 16'($urandom), 1'b1, "busy_cmd");
  endtask

  task automatic test_dtack_stuck();
    resp_mode = RespStuck;
    idle_cycles(4);
    run_txn(1'b0, 1'b1, 23'($urandom), 16'($urandom), RespStuck, 16'h5A5A, 1'b0, "stuck");
  endtask

  task automatic test_reset_mid();
    int p0;
    resp_mode   = RespNone;
    p0          = done_pulses;
    vme_cmd     = 1'b1;
    vme_wr      = 1'b0;
    vme_rd      = 1'b1;
    vme_addr    = 23'h7FFFFF;
    vme_wr_data = 16'hFFFF;
    @(posedge clk);
    #1;
    vme_cmd = 1'b0;
    idle_cycles(int'(SetupCyc) + 4);
    n_total++;
    if (as_n !== 1'b0) $display("FAIL rst_mid precondition: as_n=%b want 0", as_n);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if (as_n !== 1'b1 || ds0_n !== 1'b1 || ds1_n !== 1'b1 || write_n !== 1'b1 || d_oe !== 1'b0 ||
        a !== '0 || d_out !== '0 || am !== 6'h39 || vme_cmd_rd !== 1'b0 ||
        vme_rd_data !== '0 || vme_err !== 2'b00 || busy !== 1'b0)
      $display("FAIL rst_mid: as_n=%b write_n=%b d_oe=%b a=%h d_out=%h cmd_rd=%b rd=%h err=%b busy=%b",
               as_n, write_n, d_oe, a, d_out, vme_cmd_rd, vme_rd_data, vme_err, busy);
    else n_pass++;
    model_rd = 16'h0000;
    idle_cycles(int'(TimeoutCyc) + 10);
    n_total++;
    if (done_pulses != p0) $display("FAIL rst_mid pulses: got %0d want 0", done_pulses - p0);
    else n_pass++;
    resp_mode = RespDtack;
    idle_cycles(4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic wr, rd;
      int   mode;
      if ($urandom_range(0, 7) == 0) begin
        wr = 1'($urandom);
        rd = wr;
      end else begin
        wr = 1'($urandom);
        rd = ~wr;
      end
      mode = $urandom_range(0, 3);
      run_txn(wr, rd, 23'($urandom), 16'($urandom), mode, 16'($urandom), 1'b0, "random");
    end
  endtask

  initial begin
    rst         = 1'b1;
    vme_cmd     = 1'b0;
    vme_addr    = '0;
    vme_wr      = 1'b0;
    vme_rd      = 1'b0;
    vme_wr_data = '0;
    d_in        = '0;
    dtack_n     = 1'b1;
    berr_n      = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_write();
    test_timeout();
    test_berr();
    test_illegal();
    test_cmd_while_busy();
    test_reset_mid();
    test_dtack_stuck();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
